// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the AXI read-data buffer (RDF) that feeds the APB register file.
package apb2axi_pkg;
  localparam int RDF_NUM_TAGS   = 16;
  localparam int RDF_MAX_BEATS  = 16;
  localparam int RDF_AXI_DATA_W = 64;
  localparam int RDF_APB_DATA_W = 32;
  localparam int RDF_RATIO      = RDF_AXI_DATA_W / RDF_APB_DATA_W;
  localparam int RDF_CNT_W      = $clog2(RDF_MAX_BEATS + 1);
  localparam int RDF_SUB_W      = (RDF_RATIO > 1) ? $clog2(RDF_RATIO) : 1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [RDF_CNT_W-1:0] wr_cnt;
    logic [RDF_CNT_W-1:0] rd_beat;
    logic [RDF_SUB_W-1:0] rd_sub;
    logic                 filled;
    logic [1:0]           worst_resp;
  } rdf_tag_ctx_t;

  typedef enum logic [1:0] {RDF_IDLE, RDF_PEND, RDF_VALID} rdf_srv_state_e;

  // EXOKAY carries no error information, so it ranks as OKAY.
  function automatic logic [1:0] rdf_resp_merge(input logic [1:0] worst, input logic [1:0] resp);
    logic [1:0] r;
    r = (resp == AXI_RESP_EXOKAY) ? AXI_RESP_OKAY : resp;
    return (r > worst) ? r : worst;
  endfunction
endpackage

// File: rtl/apb2axi_rdf_mem.sv
// Beat storage for the read-data buffer: one write port, one asynchronous read port.
module apb2axi_rdf_mem #(
  parameter int DEPTH = 256,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/apb2axi_rdf.sv
// AXI R-channel capture per tag, burst-done reporting, and word-at-a-time serving to the
// register file (wide beats split least-significant word first).
module apb2axi_rdf import apb2axi_pkg::*; #(
  parameter int NUM_TAGS   = RDF_NUM_TAGS,
  parameter int MAX_BEATS  = RDF_MAX_BEATS,
  parameter int AXI_DATA_W = RDF_AXI_DATA_W,
  parameter int APB_DATA_W = RDF_APB_DATA_W
) (
  input  logic                        pclk,
  input  logic                        presetn,
  input  logic                        rvalid,
  output logic                        rready,
  input  logic [$clog2(NUM_TAGS)-1:0] rid,
  input  logic [AXI_DATA_W-1:0]       rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  output logic                        rdf_dir_done_vld,
  output logic [$clog2(NUM_TAGS)-1:0] rdf_dir_done_tag,
  output logic [1:0]                  rdf_dir_done_resp,
  output logic [7:0]                  rdf_dir_done_beats,
  input  logic                        rdf_reg_data_req,
  input  logic [$clog2(NUM_TAGS)-1:0] rdf_reg_data_req_tag,
  output logic                        rdf_reg_data_vld,
  input  logic                        rdf_reg_data_rdy,
  output logic [APB_DATA_W-1:0]       rdf_reg_data_out,
  output logic                        rdf_reg_data_last
);
  localparam int TAG_W  = $clog2(NUM_TAGS);
  localparam int BEAT_W = $clog2(MAX_BEATS);
  localparam int RATIO  = AXI_DATA_W / APB_DATA_W;
  localparam int CNT_W  = RDF_CNT_W;
  localparam int SUB_W  = RDF_SUB_W;
  localparam int AW     = TAG_W + BEAT_W;

  rdf_tag_ctx_t [NUM_TAGS-1:0] ctx_q, ctx_d;
  rdf_srv_state_e              state_q, state_d;
  logic [TAG_W-1:0]            pend_tag_q, pend_tag_d, out_tag_q, out_tag_d;
  logic [APB_DATA_W-1:0]       out_q, out_d;
  logic                        last_q, last_d, rready_q;
  logic                        done_vld_q, done_vld_d;
  logic [TAG_W-1:0]            done_tag_q, done_tag_d;
  logic [1:0]                  done_resp_q, done_resp_d;
  logic [7:0]                  done_beats_q, done_beats_d;

  logic                        mem_we;
  logic [AW-1:0]               mem_waddr;
  logic [AXI_DATA_W-1:0]       mem_rdata;
  logic [RATIO-1:0][APB_DATA_W-1:0] mem_words;
  rdf_tag_ctx_t                cons_ctx, cap_ctx, srv_ctx;
  logic [TAG_W-1:0]            srv_tag;
  logic                        srv_want, srv_hit, srv_last;

  // A fresh request is served in the same edge it is seen, so it bypasses pend_tag.
  assign srv_want  = (state_q == RDF_PEND) || (rdf_reg_data_req && state_q != RDF_VALID);
  assign srv_tag   = (rdf_reg_data_req && state_q != RDF_VALID) ? rdf_reg_data_req_tag : pend_tag_q;
  assign srv_ctx   = ctx_q[srv_tag];
  assign srv_hit   = srv_want && (srv_ctx.rd_beat < srv_ctx.wr_cnt);
  assign srv_last  = srv_ctx.filled && (srv_ctx.rd_beat == srv_ctx.wr_cnt - 1'b1) &&
                     (srv_ctx.rd_sub == SUB_W'(RATIO - 1));
  assign mem_words = mem_rdata;

  apb2axi_rdf_mem #(.DEPTH(NUM_TAGS * MAX_BEATS), .W(AXI_DATA_W), .AW(AW)) u_mem (
    .clk(pclk), .we(mem_we), .waddr(mem_waddr), .wdata(rdata),
    .raddr({srv_tag, srv_ctx.rd_beat[BEAT_W-1:0]}), .rdata(mem_rdata)
  );

  always_comb begin
    ctx_d        = ctx_q;
    state_d      = state_q;
    pend_tag_d   = pend_tag_q;
    out_tag_d    = out_tag_q;
    out_d        = out_q;
    last_d       = last_q;
    done_vld_d   = 1'b0;
    done_tag_d   = done_tag_q;
    done_resp_d  = done_resp_q;
    done_beats_d = done_beats_q;
    cons_ctx     = ctx_q[out_tag_q];
    cap_ctx      = '0;
    mem_we       = 1'b0;
    mem_waddr    = '0;

    unique case (state_q)
      RDF_VALID: begin
        if (rdf_reg_data_rdy) begin
          state_d = RDF_IDLE;
          if (last_q) begin
            cons_ctx = '0;
          end else if (cons_ctx.rd_sub == SUB_W'(RATIO - 1)) begin
            cons_ctx.rd_sub  = '0;
            cons_ctx.rd_beat = cons_ctx.rd_beat + 1'b1;
          end else begin
            cons_ctx.rd_sub = cons_ctx.rd_sub + 1'b1;
          end
          ctx_d[out_tag_q] = cons_ctx;
        end
      end
      default: begin
        if (srv_hit) begin
          state_d   = RDF_VALID;
          out_d     = mem_words[srv_ctx.rd_sub];
          last_d    = srv_last;
          out_tag_d = srv_tag;
        end else if (srv_want) begin
          state_d    = RDF_PEND;
          pend_tag_d = srv_tag;
        end
      end
    endcase

    // Capture is applied after consume so a tag freed this cycle restarts at slot 0.
    if (rvalid && rready_q) begin
      cap_ctx = ctx_d[rid];
      if (cap_ctx.wr_cnt == CNT_W'(MAX_BEATS)) begin
        cap_ctx.worst_resp = AXI_RESP_SLVERR;
      end else begin
        mem_we             = 1'b1;
        mem_waddr          = {rid, cap_ctx.wr_cnt[BEAT_W-1:0]};
        cap_ctx.wr_cnt     = cap_ctx.wr_cnt + 1'b1;
        cap_ctx.worst_resp = rdf_resp_merge(cap_ctx.worst_resp, rresp);
      end
      if (rlast) begin
        cap_ctx.filled = 1'b1;
        done_vld_d     = 1'b1;
        done_tag_d     = rid;
        done_resp_d    = cap_ctx.worst_resp;
        done_beats_d   = 8'(cap_ctx.wr_cnt);
      end
      ctx_d[rid] = cap_ctx;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      ctx_q        <= '0;
      state_q      <= RDF_IDLE;
      pend_tag_q   <= '0;
      out_tag_q    <= '0;
      out_q        <= '0;
      last_q       <= 1'b0;
      rready_q     <= 1'b0;
      done_vld_q   <= 1'b0;
      done_tag_q   <= '0;
      done_resp_q  <= '0;
      done_beats_q <= '0;
    end else begin
      ctx_q        <= ctx_d;
      state_q      <= state_d;
      pend_tag_q   <= pend_tag_d;
      out_tag_q    <= out_tag_d;
      out_q        <= out_d;
      last_q       <= last_d;
      rready_q     <= 1'b1;
      done_vld_q   <= done_vld_d;
      done_tag_q   <= done_tag_d;
      done_resp_q  <= done_resp_d;
      done_beats_q <= done_beats_d;
    end
  end

  assign rready             = rready_q;
  assign rdf_reg_data_vld   = (state_q == RDF_VALID);
  assign rdf_reg_data_out   = out_q;
  assign rdf_reg_data_last  = last_q;
  assign rdf_dir_done_vld   = done_vld_q;
  assign rdf_dir_done_tag   = done_tag_q;
  assign rdf_dir_done_resp  = done_resp_q;
  assign rdf_dir_done_beats = done_beats_q;
endmodule

// File: tb/tb_apb2axi_rdf.sv
// Bench for apb2axi_rdf: queue-based model of per-tag beat buffers and expected done reports.
module tb_apb2axi_rdf;
  logic        pclk = 1'b0, presetn = 1'b0;
  logic        rvalid = 1'b0, rready, rlast = 1'b0;
  logic [3:0]  rid = '0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        done_vld;
  logic [3:0]  done_tag;
  logic [1:0]  done_resp;
  logic [7:0]  done_beats;
  logic        req = 1'b0, vld, rdy = 1'b0, dlast;
  logic [3:0]  req_tag = '0;
  logic [31:0] dout;

  int n_cmp = 0, n_err = 0;

  always #5 pclk = ~pclk;

  apb2axi_rdf dut (
    .pclk(pclk), .presetn(presetn),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rdf_dir_done_vld(done_vld), .rdf_dir_done_tag(done_tag),
    .rdf_dir_done_resp(done_resp), .rdf_dir_done_beats(done_beats),
    .rdf_reg_data_req(req), .rdf_reg_data_req_tag(req_tag),
    .rdf_reg_data_vld(vld), .rdf_reg_data_rdy(rdy),
    .rdf_reg_data_out(dout), .rdf_reg_data_last(dlast)
  );

  // ---------------- reference model ----------------
  logic [63:0] m_beats [16][$];
  logic [1:0]  m_resp [16];
  bit          m_filled [16];
  int          m_rd [16];
  logic [13:0] exp_done [$];
  logic [13:0] got_done [$];

  function automatic void m_clear(input int t);
    m_beats[t].delete();
    m_resp[t]   = 2'b00;
    m_filled[t] = 1'b0;
    m_rd[t]     = 0;
  endfunction

  function automatic void m_beat(input int t, input logic [63:0] d, input logic [1:0] r, input bit l);
    logic [1:0] rn;
    rn = (r == 2'b01) ? 2'b00 : r;
    if (m_beats[t].size() >= 16) m_resp[t] = 2'b10;
    else begin
      m_beats[t].push_back(d);
      if (rn > m_resp[t]) m_resp[t] = rn;
    end
    if (l) begin
      m_filled[t] = 1'b1;
      exp_done.push_back({4'(t), m_resp[t], 8'(m_beats[t].size())});
    end
  endfunction

  function automatic void m_word(input int t, output logic [31:0] d, output logic l);
    int i;
    logic [63:0] b;
    i = m_rd[t];
    b = m_beats[t][i / 2];
    d = (i % 2 == 1) ? b[63:32] : b[31:0];
    l = m_filled[t] && (i == 2 * m_beats[t].size() - 1);
    m_rd[t]++;
    if (l) m_clear(t);
  endfunction

  always @(negedge pclk)
    if (done_vld === 1'b1) got_done.push_back({done_tag, done_resp, done_beats});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_beat(input int t, input logic [63:0] d, input logic [1:0] r, input bit l);
    rvalid = 1'b1; rid = 4'(t); rdata = d; rresp = r; rlast = l;
    m_beat(t, d, r, l);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic do_read(input int t, input int hold, output logic [31:0] d, output logic l,
                         output int lat);
    req = 1'b1; req_tag = 4'(t);
    tick();
    req = 1'b0; lat = -1; d = 'x; l = 1'bx;
    for (int i = 1; i <= 64; i++) begin
      if (vld === 1'b1) begin lat = i; break; end
      tick();
    end
    if (lat < 0) return;
    d = dout; l = dlast;
    repeat (hold) tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    presetn = 1'b0;
    tick(); tick();
    n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL rst_rready: got %b want 0", rready); end
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b want 0", vld); end
    n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL rst_out: got %h want 0", dout); end
    n_cmp++; if (dlast !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b want 0", dlast); end
    n_cmp++; if (done_vld !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done_vld); end
    presetn = 1'b1;
    tick();
    n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL rst_rready_up: got %b want 1", rready); end
  endtask

  task automatic test_basic();
    logic [31:0] ed, gd; logic el, gl; int lat; bit ok;
    logic [31:0] spec_w [4];
    spec_w[0] = 32'h3333_4444; spec_w[1] = 32'h1111_2222;
    spec_w[2] = 32'h7777_8888; spec_w[3] = 32'h5555_6666;
    send_beat(3, 64'h1111_2222_3333_4444, 2'b00, 1'b0);
    send_beat(3, 64'h5555_6666_7777_8888, 2'b00, 1'b1);
    tick();
    ok = (got_done.size() == 1) && (got_done[0] === {4'd3, 2'd0, 8'd2});
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_done: got %p want tag3 resp0 beats2", got_done); end
    got_done.delete(); exp_done.delete();
    for (int w = 0; w < 4; w++) begin
      m_word(3, ed, el);
      do_read(3, 0, gd, gl, lat);
      n_cmp++;
      if (lat != 1 || gd !== spec_w[w] || gl !== (w == 3)) begin
        n_err++;
        $display("FAIL basic_rd%0d: lat %0d data %h last %b, want lat 1 data %h last %b",
                 w, lat, gd, gl, spec_w[w], el);
      end
    end
    // tag 3 must be free again: a new one-beat burst reports 1 beat
    send_beat(3, {$urandom, $urandom}, 2'b01, 1'b1);
    tick();
    ok = (got_done.size() == exp_done.size());
    foreach (exp_done[i]) if (ok && got_done[i] !== exp_done[i]) ok = 0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_reuse_done: got %p want %p", got_done, exp_done); end
    got_done.delete(); exp_done.delete();
    repeat (2) begin
      m_word(3, ed, el);
      do_read(3, 0, gd, gl, lat);
      n_cmp++;
      if (lat != 1 || gd !== ed || gl !== el) begin
        n_err++;
        $display("FAIL basic_reuse_rd: lat %0d data %h last %b, want lat 1 data %h last %b", lat, gd, gl, ed, el);
      end
    end
  endtask

  task automatic test_wait_for_data();
    logic [31:0] ed, gd; logic el, gl; int lat; bit ok;
    logic [63:0] d;
    d = {$urandom, $urandom};
    req = 1'b1; req_tag = 4'd5;
    tick();
    req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL wait_idle%0d: vld %b want 0", c, vld); end
      tick();
    end
    send_beat(5, d, 2'b00, 1'b1);
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL wait_capture_edge: vld %b want 0", vld); end
    tick();
    m_word(5, ed, el);
    n_cmp++;
    if (vld !== 1'b1 || dout !== ed || dlast !== el) begin
      n_err++;
      $display("FAIL wait_first: vld %b data %h last %b, want vld 1 data %h last %b", vld, dout, dlast, ed, el);
    end
    rdy = 1'b1; tick(); rdy = 1'b0;
    m_word(5, ed, el);
    do_read(5, 0, gd, gl, lat);
    n_cmp++;
    if (lat != 1 || gd !== ed || gl !== el) begin
      n_err++;
      $display("FAIL wait_second: lat %0d data %h last %b, want lat 1 data %h last %b", lat, gd, gl, ed, el);
    end
    tick();
    ok = (got_done.size() == exp_done.size());
    foreach (exp_done[i]) if (ok && got_done[i] !== exp_done[i]) ok = 0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wait_done: got %p want %p", got_done, exp_done); end
    got_done.delete(); exp_done.delete();
  endtask

  task automatic test_interleave();
    logic [31:0] ed, gd; logic el, gl; int lat; bit ok;
    int tg [2];
    tg[0] = 7; tg[1] = 2;
    send_beat(7, {$urandom, $urandom}, 2'b10, 1'b0);
    send_beat(2, {$urandom, $urandom}, 2'b00, 1'b0);
    send_beat(7, {$urandom, $urandom}, 2'b00, 1'b0);
    send_beat(2, {$urandom, $urandom}, 2'b01, 1'b0);
    send_beat(7, {$urandom, $urandom}, 2'b00, 1'b1);
    send_beat(2, {$urandom, $urandom}, 2'b00, 1'b1);
    tick();
    ok = (got_done.size() == 2) && (got_done[0] === {4'd7, 2'd2, 8'd3}) && (got_done[1] === {4'd2, 2'd0, 8'd3});
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ileave_done: got %p want tag7 resp2 then tag2 resp0", got_done); end
    got_done.delete(); exp_done.delete();
    foreach (tg[j]) begin
      repeat (6) begin
        m_word(tg[j], ed, el);
        do_read(tg[j], 0, gd, gl, lat);
        n_cmp++;
        if (lat != 1 || gd !== ed || gl !== el) begin
          n_err++;
          $display("FAIL ileave_rd: tag %0d lat %0d data %h last %b, want lat 1 data %h last %b",
                   tg[j], lat, gd, gl, ed, el);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] ed, gd; logic el, gl; int lat; bit ok; int drops;
    drops = 0;
    for (int b = 0; b < 17; b++) begin
      if (rready !== 1'b1) drops++;
      send_beat(9, {$urandom, $urandom}, 2'b00, b == 16);
    end
    if (rready !== 1'b1) drops++;
    n_cmp++; if (drops != 0) begin n_err++; $display("FAIL ovf_rready: low cycles %0d want 0", drops); end
    tick();
    ok = (got_done.size() == 1) && (got_done[0] === {4'd9, 2'd2, 8'd16});
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_done: got %p want tag9 resp2 beats16", got_done); end
    got_done.delete(); exp_done.delete();
    repeat (32) begin
      m_word(9, ed, el);
      do_read(9, 0, gd, gl, lat);
      n_cmp++;
      if (lat != 1 || gd !== ed || gl !== el) begin
        n_err++;
        $display("FAIL ovf_rd: lat %0d data %h last %b, want lat 1 data %h last %b", lat, gd, gl, ed, el);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] ed, gd; logic el, gl; int lat;
    send_beat(4, {$urandom, $urandom}, 2'b00, 1'b1);
    req = 1'b1; req_tag = 4'd4;
    tick();
    req = 1'b0;
    m_word(4, ed, el);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin req = 1'b1; req_tag = 4'd4; end
      n_cmp++;
      if (vld !== 1'b1 || dout !== ed || dlast !== el) begin
        n_err++;
        $display("FAIL hold_c%0d: vld %b data %h last %b, want vld 1 data %h last %b", c, vld, dout, dlast, ed, el);
      end
      tick();
      req = 1'b0;
    end
    rdy = 1'b1; tick(); rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL hold_ignored_req%0d: vld %b want 0", c, vld); end
      tick();
    end
    m_word(4, ed, el);
    do_read(4, 0, gd, gl, lat);
    n_cmp++;
    if (lat != 1 || gd !== ed || gl !== el) begin
      n_err++;
      $display("FAIL hold_second: lat %0d data %h last %b, want lat 1 data %h last %b", lat, gd, gl, ed, el);
    end
    got_done.delete(); exp_done.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ed, gd; logic el, gl; int lat; bit ok;
    send_beat(13, {$urandom, $urandom}, 2'b00, 1'b1);
    req = 1'b1; req_tag = 4'd13;
    tick();
    req = 1'b0;
    m_word(13, ed, el);
    n_cmp++;
    if (vld !== 1'b1 || dout !== ed) begin
      n_err++; $display("FAIL b2b_t13: vld %b data %h, want vld 1 data %h", vld, dout, ed);
    end
    // consume coincides with another tag's done-producing beat
    rdy = 1'b1;
    send_beat(12, {$urandom, $urandom}, 2'b11, 1'b1);
    rdy = 1'b0;
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL b2b_consume: vld %b want 0", vld); end
    // request and first beat for an empty tag in the same cycle
    req = 1'b1; req_tag = 4'd14;
    send_beat(14, {$urandom, $urandom}, 2'b00, 1'b1);
    req = 1'b0;
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL b2b_same_edge: vld %b want 0", vld); end
    tick();
    m_word(14, ed, el);
    n_cmp++;
    if (vld !== 1'b1 || dout !== ed || dlast !== el) begin
      n_err++;
      $display("FAIL b2b_t14: vld %b data %h last %b, want vld 1 data %h last %b", vld, dout, dlast, ed, el);
    end
    rdy = 1'b1; tick(); rdy = 1'b0;
    ok = (got_done.size() == exp_done.size());
    foreach (exp_done[i]) if (ok && got_done[i] !== exp_done[i]) ok = 0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_done: got %p want %p", got_done, exp_done); end
    got_done.delete(); exp_done.delete();
    foreach (m_rd[i]) ;
    for (int k = 0; k < 4; k++) begin
      int t;
      t = (k == 0) ? 13 : (k == 3) ? 14 : 12;
      m_word(t, ed, el);
      do_read(t, k, gd, gl, lat);
      n_cmp++;
      if (lat != 1 || gd !== ed || gl !== el) begin
        n_err++;
        $display("FAIL b2b_rd: tag %0d lat %0d data %h last %b, want lat 1 data %h last %b", t, lat, gd, gl, ed, el);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ed, gd; logic el, gl; int lat; bit ok;
    int tg [4]; int len [4]; int rem [4]; int total, base, k;
    for (int iter = 0; iter < 3; iter++) begin
      base = $urandom_range(0, 15);
      total = 0;
      for (int j = 0; j < 4; j++) begin
        tg[j] = (base + 5 * j) % 16;
        len[j] = $urandom_range(1, 16);
        rem[j] = len[j];
        total += len[j];
      end
      while (total > 0) begin
        k = $urandom_range(0, 3);
        if (rem[k] == 0) continue;
        send_beat(tg[k], {$urandom, $urandom}, 2'($urandom_range(0, 3)), rem[k] == 1);
        rem[k]--; total--;
        if ($urandom_range(0, 3) == 0) tick();
      end
      tick();
      ok = (got_done.size() == exp_done.size());
      foreach (exp_done[i]) if (ok && got_done[i] !== exp_done[i]) ok = 0;
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_done%0d: got %p want %p", iter, got_done, exp_done); end
      got_done.delete(); exp_done.delete();
      for (int j = 0; j < 4; j++) begin
        repeat (2 * len[j]) begin
          m_word(tg[j], ed, el);
          do_read(tg[j], $urandom_range(0, 2), gd, gl, lat);
          n_cmp++;
          if (lat != 1 || gd !== ed || gl !== el) begin
            n_err++;
            $display("FAIL rnd_rd: tag %0d lat %0d data %h last %b, want lat 1 data %h last %b",
                     tg[j], lat, gd, gl, ed, el);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed, gd; logic el, gl; int lat; bit ok;
    send_beat(6, {$urandom, $urandom}, 2'b10, 1'b0);
    send_beat(6, {$urandom, $urandom}, 2'b00, 1'b0);
    req = 1'b1; req_tag = 4'd6;
    tick();
    req = 1'b0;
    n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL rmid_pre: vld %b want 1", vld); end
    presetn = 1'b0;
    tick();
    n_cmp++;
    if (vld !== 1'b0 || rready !== 1'b0 || dout !== 32'h0 || dlast !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_rst: vld %b rready %b out %h last %b, want all 0", vld, rready, dout, dlast);
    end
    presetn = 1'b1;
    tick();
    for (int t = 0; t < 16; t++) m_clear(t);
    got_done.delete(); exp_done.delete();
    send_beat(6, {$urandom, $urandom}, 2'b00, 1'b1);
    tick();
    ok = (got_done.size() == 1) && (got_done[0] === {4'd6, 2'd0, 8'd1});
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_done: got %p want tag6 resp0 beats1", got_done); end
    got_done.delete(); exp_done.delete();
    repeat (2) begin
      m_word(6, ed, el);
      do_read(6, 0, gd, gl, lat);
      n_cmp++;
      if (lat != 1 || gd !== ed || gl !== el) begin
        n_err++;
        $display("FAIL rmid_rd: lat %0d data %h last %b, want lat 1 data %h last %b", lat, gd, gl, ed, el);
      end
    end
  endtask

  initial begin
    for (int t = 0; t < 16; t++) m_clear(t);
    test_reset();
    test_basic();
    test_wait_for_data();
    test_interleave();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
